intan_cmd_scheduler: RTL and testbench

Frame-level command scheduler for the Intan SPI engine. Sequences one 35-slot frame per timestep: 32 CONVERT commands, then 3 auxiliary commands from a host-writable 16-entry command list. Hands each 16-bit command to the SPI shifter over a valid/ready handshake. Tracks the frame timestamp and stops after `max_timestep` frames, or at a frame boundary in continuous mode.

---
 rtl/intan_cmd_scheduler.sv | 117 +++++++++++
 tb/tb_intan_cmd_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intan_cmd_scheduler.sv
// rtl/intan_cmd_scheduler.sv - frame-level command scheduler for the Intan SPI engine
// Issues 32 CONVERT slots plus 3 auxiliary list slots per frame over a valid/ready handshake.
module intan_cmd_scheduler #(
  parameter int NUM_CH     = 32,
  parameter int AUX_SLOTS  = 3,
  parameter int LIST_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_start,
  input  logic        spi_continuous,
  input  logic [31:0] max_timestep,
  input  logic [3:0]  aux_len,
  input  logic        cmd_wr_en,
  input  logic [3:0]  cmd_wr_addr,
  input  logic [15:0] cmd_wr_data,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [15:0] cmd_data,
  output logic        frame_start,
  output logic [5:0]  channel,
  output logic [3:0]  instr_counter,
  output logic [31:0] timestamp,
  output logic        busy,
  output logic        done
);

  localparam int LAST_SLOT = NUM_CH + AUX_SLOTS - 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [15:0] cmd_list [LIST_DEPTH];
  logic [3:0]  aux_len_q;
  logic        cont_q;

  logic        aux_slot;
  logic        last_slot;
  logic        finish;
  logic [3:0]  ic_next;
  logic [5:0]  ch_next;
  logic [31:0] ts_next;
  logic [31:0] max_eff;
  logic [15:0] next_cmd;

  assign cmd_valid   = (state == RUN);
  assign busy        = (state == RUN);
  assign frame_start = (state == RUN) && (channel == 6'd0);

  assign aux_slot  = (channel >= 6'(NUM_CH));
  assign last_slot = (channel == 6'(LAST_SLOT));
  assign ts_next   = timestamp + 32'd1;
  assign max_eff   = (max_timestep == 32'd0) ? 32'd1 : max_timestep;

  // A run started in continuous mode ends at the first frame boundary that sees the flag cleared.
  assign finish = spi_continuous ? 1'b0 : (cont_q | (ts_next >= max_eff));

  always_comb begin
    ic_next = instr_counter;
    if (aux_slot) begin
      ic_next = (instr_counter == aux_len_q) ? 4'd0 : instr_counter + 4'd1;
    end
  end

  assign ch_next  = last_slot ? 6'd0 : channel + 6'd1;
  // The list read sees the pre-edge contents, so a same-cycle write to this entry loads the old word.
  assign next_cmd = (ch_next < 6'(NUM_CH)) ? {2'b00, ch_next, 8'h00} : cmd_list[ic_next];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LIST_DEPTH; i++) begin
        cmd_list[i] <= 16'h0000;
      end
    end else if (cmd_wr_en) begin
      cmd_list[cmd_wr_addr] <= cmd_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cmd_data      <= 16'h0000;
      channel       <= 6'd0;
      instr_counter <= 4'd0;
      timestamp     <= 32'd0;
      aux_len_q     <= 4'd0;
      cont_q        <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (spi_start) begin
          state         <= RUN;
          channel       <= 6'd0;
          timestamp     <= 32'd0;
          instr_counter <= 4'd0;
          aux_len_q     <= aux_len;
          cont_q        <= spi_continuous;
          cmd_data      <= 16'h0000;
        end
      end else if (cmd_ready) begin
        instr_counter <= ic_next;
        if (last_slot && finish) begin
          state <= IDLE;
          done  <= 1'b1;
        end else begin
          channel  <= ch_next;
          cmd_data <= next_cmd;
          if (last_slot) begin
            timestamp <= ts_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_intan_cmd_scheduler.sv
// tb/tb_intan_cmd_scheduler.sv - directed scoreboard bench for intan_cmd_scheduler
module tb_intan_cmd_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_start;
  logic        spi_continuous;
  logic [31:0] max_timestep;
  logic [3:0]  aux_len;
  logic        cmd_wr_en;
  logic [3:0]  cmd_wr_addr;
  logic [15:0] cmd_wr_data;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        frame_start;
  logic [5:0]  channel;
  logic [3:0]  instr_counter;
  logic [31:0] timestamp;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [15:0] mlist [16];
  int          mptr;
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  intan_cmd_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .spi_start      (spi_start),
    .spi_continuous (spi_continuous),
    .max_timestep   (max_timestep),
    .aux_len        (aux_len),
    .cmd_wr_en      (cmd_wr_en),
    .cmd_wr_addr    (cmd_wr_addr),
    .cmd_wr_data    (cmd_wr_data),
    .cmd_ready      (cmd_ready),
    .cmd_valid      (cmd_valid),
    .cmd_data       (cmd_data),
    .frame_start    (frame_start),
    .channel        (channel),
    .instr_counter  (instr_counter),
    .timestamp      (timestamp),
    .busy           (busy),
    .done           (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_frames(input int n, input int alen);
    for (int f = 0; f < n; f++) begin
      for (int s = 0; s < 32; s++) sb.push_back({2'b00, 6'(s), 8'h00});
      for (int a = 0; a < 3; a++) begin
        sb.push_back(mlist[mptr]);
        mptr = (mptr == alen) ? 0 : mptr + 1;
      end
    end
  endfunction

  task automatic write_list(input logic [3:0] a, input logic [15:0] d);
    cmd_wr_en = 1'b1;
    cmd_wr_addr = a;
    cmd_wr_data = d;
    tick();
    cmd_wr_en = 1'b0;
    mlist[a] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, cmd_valid, 0);
    check({tag, "_data"}, cmd_data, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_chan"}, channel, 0);
    check({tag, "_ic"}, instr_counter, 0);
    check({tag, "_ts"}, timestamp, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic start_run(input bit hold);
    spi_start = 1'b1;
    tick();
    check("start_valid", cmd_valid, 1);
    check("start_data", cmd_data, 0);
    check("start_ts", timestamp, 0);
    if (!hold) spi_start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input int stall_at, input int stall_len,
                             input int clear_at, input int wr_at, input logic [3:0] wa,
                             input logic [15:0] wd, output int acc, output int busy_c,
                             output int done_c);
    int stalled;
    bit fin;
    logic [15:0] exp_cmd;
    acc = 0; busy_c = 0; done_c = 0; stalled = 0; fin = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (acc == clear_at) spi_continuous = 1'b0;
      cmd_ready = !(acc == stall_at && stalled < stall_len);
      cmd_wr_en = (acc == wr_at);
      cmd_wr_addr = wa;
      cmd_wr_data = wd;
      if (done) begin
        done_c++;
        fin = 1'b1;
      end
      if (busy) busy_c++;
      if (fin) break;
      if (!cmd_ready) begin
        stalled++;
        check("stall_chan", channel, stall_at % 35);
        if (sb.size() != 0) check("stall_data", cmd_data, sb[0]);
      end else if (cmd_valid) begin
        check("frame_start", frame_start, (acc % 35) == 0);
        check("channel", channel, acc % 35);
        check("timestamp", timestamp, acc / 35);
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_cmd = sb.pop_front();
          check("cmd_data", cmd_data, exp_cmd);
        end
        acc++;
      end
      tick();
    end
    cmd_wr_en = 1'b0;
    cmd_ready = 1'b1;
    check("done_seen", fin, 1);
  endtask

  initial begin
    int acc, busy_c, done_c;
    reset = 1'b0;
    spi_start = 1'b0;
    spi_continuous = 1'b0;
    max_timestep = 32'd0;
    aux_len = 4'd0;
    cmd_wr_en = 1'b0;
    cmd_wr_addr = 4'd0;
    cmd_wr_data = 16'h0000;
    cmd_ready = 1'b1;
    for (int i = 0; i < 16; i++) mlist[i] = 16'h0000;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    tick();
    check("idle_valid", cmd_valid, 0);
    check("idle_busy", busy, 0);

    // finite run of three frames
    max_timestep = 32'd3;
    aux_len = 4'd0;
    mptr = 0;
    push_frames(3, 0);
    start_run(1'b0);
    run_to_done(400, -1, 0, -1, -1, 4'd0, 16'h0, acc, busy_c, done_c);
    check("fin_accepted", acc, 105);
    check("fin_busy_cycles", busy_c, 105);
    check("fin_done_pulses", done_c, 1);
    check("fin_timestamp", timestamp, 2);
    check("fin_sb_empty", sb.size(), 0);
    tick();
    check("fin_done_low", done, 0);
    check("fin_idle", busy, 0);

    // auxiliary list wrap across frames
    write_list(4'd0, 16'hE800);
    write_list(4'd1, 16'hE900);
    write_list(4'd2, 16'hEA00);
    write_list(4'd3, 16'hEB00);
    aux_len = 4'd3;
    max_timestep = 32'd2;
    mptr = 0;
    push_frames(2, 3);
    start_run(1'b0);
    run_to_done(300, -1, 0, -1, -1, 4'd0, 16'h0, acc, busy_c, done_c);
    check("aux_accepted", acc, 70);
    check("aux_ts", timestamp, 1);
    tick();

    // backpressure on slot 7
    max_timestep = 32'd1;
    mptr = 0;
    push_frames(1, 3);
    start_run(1'b0);
    run_to_done(200, 7, 5, -1, -1, 4'd0, 16'h0, acc, busy_c, done_c);
    check("bp_accepted", acc, 35);
    check("bp_busy_cycles", busy_c, 40);
    tick();

    // max_timestep of zero runs one frame
    max_timestep = 32'd0;
    mptr = 0;
    push_frames(1, 3);
    start_run(1'b0);
    run_to_done(200, -1, 0, -1, -1, 4'd0, 16'h0, acc, busy_c, done_c);
    check("zero_accepted", acc, 35);
    check("zero_busy", busy_c, 35);
    tick();

    // continuous mode cleared mid-frame 3
    spi_continuous = 1'b1;
    max_timestep = 32'd1;
    mptr = 0;
    push_frames(4, 3);
    start_run(1'b0);
    run_to_done(400, -1, 0, 115, -1, 4'd0, 16'h0, acc, busy_c, done_c);
    check("cont_accepted", acc, 140);
    check("cont_ts", timestamp, 3);
    check("cont_done", done_c, 1);
    tick();

    // list write colliding with the slot-32 load
    spi_continuous = 1'b0;
    max_timestep = 32'd2;
    mptr = 0;
    push_frames(1, 3);
    mlist[0] = 16'hC0DE;
    push_frames(1, 3);
    start_run(1'b0);
    run_to_done(300, -1, 0, -1, 31, 4'd0, 16'hC0DE, acc, busy_c, done_c);
    check("coll_accepted", acc, 70);
    check("coll_sb_empty", sb.size(), 0);
    tick();

    // restart with start held high, then reset mid-run
    max_timestep = 32'd1;
    mptr = 0;
    push_frames(1, 3);
    start_run(1'b1);
    run_to_done(200, -1, 0, -1, -1, 4'd0, 16'h0, acc, busy_c, done_c);
    check("rs_accepted", acc, 35);
    tick();
    check("restart_busy", busy, 1);
    check("restart_chan", channel, 0);
    spi_start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    #2;
    reset = 1'b1;
    tick();
    tick();
    check("post_reset_valid", cmd_valid, 0);
    check("post_reset_busy", busy, 0);

    // list contents cleared by reset
    sb.delete();
    for (int i = 0; i < 16; i++) mlist[i] = 16'h0000;
    aux_len = 4'd1;
    mptr = 0;
    push_frames(1, 1);
    start_run(1'b0);
    run_to_done(200, -1, 0, -1, -1, 4'd0, 16'h0, acc, busy_c, done_c);
    check("clr_accepted", acc, 35);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
